// File: rtl/generic_bus_pkg.sv
// Shared types and constants for the generic bus arbiter.
package generic_bus_pkg;

   typedef enum logic [0:0] {IDLE, OWN} arb_state_t;

   localparam int unsigned BURST_LEN_W = 4;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first asserted request at or after ptr_i, ascending modulo NUM_MGRS.
module rr_pick #(
   parameter int unsigned NUM_MGRS = 4,
   parameter int unsigned IDX_W    = $clog2(NUM_MGRS)
) (
   input  logic [NUM_MGRS-1:0] req_i,
   input  logic [IDX_W-1:0]    ptr_i,
   output logic [IDX_W-1:0]    idx_o,
   output logic                any_o
);

   logic [IDX_W:0] cand;
   logic           found;

   // ptr_i < NUM_MGRS and k < NUM_MGRS, so a single conditional subtract wraps the sum.
   always_comb begin
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      for (int unsigned k = 0; k < NUM_MGRS; k++) begin
         cand = {1'b0, ptr_i} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(NUM_MGRS)) begin
            cand = cand - (IDX_W+1)'(NUM_MGRS);
         end
         if (!found && req_i[cand[IDX_W-1:0]]) begin
            idx_o = cand[IDX_W-1:0];
            found = 1'b1;
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/generic_bus_arbiter.sv
// Round-robin arbiter granting one of NUM_MGRS managers ownership of a shared bus,
// with burst hold, stall hold, error/early-drop release and registered bus requests.
module generic_bus_arbiter
   import generic_bus_pkg::*;
#(
   parameter int unsigned NUM_MGRS   = 4,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                                clk_i,
   input  logic                                nReset_i,
   input  logic [NUM_MGRS-1:0]                 mREn_i,
   input  logic [NUM_MGRS-1:0]                 mWEn_i,
   input  logic [NUM_MGRS*ADDR_WIDTH-1:0]      mAddr_i,
   input  logic [NUM_MGRS*DATA_WIDTH-1:0]      mWData_i,
   input  logic [NUM_MGRS*(DATA_WIDTH/8)-1:0]  mWStrb_i,
   input  logic [NUM_MGRS-1:0]                 mIsBurst_i,
   input  logic [NUM_MGRS*BURST_LEN_W-1:0]     mBurstLen_i,
   output logic [NUM_MGRS*DATA_WIDTH-1:0]      mRData_o,
   output logic [NUM_MGRS-1:0]                 mError_o,
   output logic [NUM_MGRS-1:0]                 mBusy_o,
   output logic                                bREn_o,
   output logic                                bWEn_o,
   output logic [ADDR_WIDTH-1:0]               bAddr_o,
   output logic [DATA_WIDTH-1:0]               bWData_o,
   output logic [DATA_WIDTH/8-1:0]             bWStrb_o,
   output logic                                bIsBurst_o,
   output logic [BURST_LEN_W-1:0]              bBurstLen_o,
   input  logic [DATA_WIDTH-1:0]               bRData_i,
   input  logic                                bError_i,
   input  logic                                bBusy_i,
   output logic [2:0]                          grantIdx_o,
   output logic                                grantValid_o
);

   localparam int unsigned IdxW  = $clog2(NUM_MGRS);
   localparam int unsigned StrbW = DATA_WIDTH / 8;

   arb_state_t             state_q;
   logic [IdxW-1:0]        ptr_q;
   logic [IdxW-1:0]        owner_q;
   logic [BURST_LEN_W-1:0] beats_q;
   logic                   b_ren_q;
   logic                   b_wen_q;
   logic [ADDR_WIDTH-1:0]  b_addr_q;
   logic [DATA_WIDTH-1:0]  b_wdata_q;
   logic [StrbW-1:0]       b_wstrb_q;
   logic                   b_is_burst_q;
   logic [BURST_LEN_W-1:0] b_burst_len_q;

   logic [NUM_MGRS-1:0]    req;
   logic [IdxW-1:0]        win_idx;
   logic                   win_any;
   logic [IdxW-1:0]        sel_idx;
   logic                   rel;

   assign req = mREn_i | mWEn_i;

   rr_pick #(
      .NUM_MGRS (NUM_MGRS),
      .IDX_W    (IdxW)
   ) u_rr_pick (
      .req_i (req),
      .ptr_i (ptr_q),
      .idx_o (win_idx),
      .any_o (win_any)
   );

   // Fields are taken from the arbitration winner in IDLE and from the owner in OWN.
   assign sel_idx = (state_q == OWN) ? owner_q : win_idx;
   assign rel     = (beats_q == '0) || bError_i || !req[owner_q];

   always_ff @(posedge clk_i or negedge nReset_i) begin
      if (!nReset_i) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         owner_q       <= '0;
         beats_q       <= '0;
         b_ren_q       <= 1'b0;
         b_wen_q       <= 1'b0;
         b_addr_q      <= '0;
         b_wdata_q     <= '0;
         b_wstrb_q     <= '0;
         b_is_burst_q  <= 1'b0;
         b_burst_len_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (win_any) begin
                  owner_q       <= win_idx;
                  b_ren_q       <= mREn_i[sel_idx];
                  b_wen_q       <= mWEn_i[sel_idx];
                  b_addr_q      <= mAddr_i[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
                  b_wdata_q     <= mWData_i[sel_idx*DATA_WIDTH +: DATA_WIDTH];
                  b_wstrb_q     <= mWStrb_i[sel_idx*StrbW +: StrbW];
                  b_is_burst_q  <= mIsBurst_i[sel_idx];
                  b_burst_len_q <= mBurstLen_i[sel_idx*BURST_LEN_W +: BURST_LEN_W];
                  beats_q       <= mIsBurst_i[sel_idx] ?
                                   mBurstLen_i[sel_idx*BURST_LEN_W +: BURST_LEN_W] : '0;
                  state_q       <= OWN;
               end else begin
                  b_ren_q <= 1'b0;
                  b_wen_q <= 1'b0;
               end
            end
            OWN: begin
               if (!bBusy_i) begin
                  if (rel) begin
                     b_ren_q <= 1'b0;
                     b_wen_q <= 1'b0;
                     ptr_q   <= (owner_q == IdxW'(NUM_MGRS - 1)) ? '0 : owner_q + 1'b1;
                     state_q <= IDLE;
                  end else begin
                     beats_q       <= beats_q - 1'b1;
                     b_ren_q       <= mREn_i[sel_idx];
                     b_wen_q       <= mWEn_i[sel_idx];
                     b_addr_q      <= mAddr_i[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
                     b_wdata_q     <= mWData_i[sel_idx*DATA_WIDTH +: DATA_WIDTH];
                     b_wstrb_q     <= mWStrb_i[sel_idx*StrbW +: StrbW];
                     b_is_burst_q  <= mIsBurst_i[sel_idx];
                     b_burst_len_q <= mBurstLen_i[sel_idx*BURST_LEN_W +: BURST_LEN_W];
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Only the owner sees the live bus response; everyone else is stalled while requesting.
   always_comb begin
      mRData_o = '0;
      mError_o = '0;
      mBusy_o  = req;
      if (state_q == OWN) begin
         mRData_o[owner_q*DATA_WIDTH +: DATA_WIDTH] = bRData_i;
         mError_o[owner_q] = bError_i;
         mBusy_o[owner_q]  = bBusy_i;
      end
   end

   assign bREn_o       = b_ren_q;
   assign bWEn_o       = b_wen_q;
   assign bAddr_o      = b_addr_q;
   assign bWData_o     = b_wdata_q;
   assign bWStrb_o     = b_wstrb_q;
   assign bIsBurst_o   = b_is_burst_q;
   assign bBurstLen_o  = b_burst_len_q;
   assign grantIdx_o   = 3'(owner_q);
   assign grantValid_o = (state_q == OWN);

endmodule
